// File: rtl/matrix_inverter_pkg.sv
// Shared types for the GF(2) encoding-matrix inverter: matrix order, FSM states
// and an identity-matrix helper.
package matrix_inverter_pkg;

  localparam int D = 0;
  localparam int N = 8 + D;

  // [r][c] is row r, column c.
  typedef logic [N-1:0][N-1:0] nn_matrix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SWAP = 2'd1,
    ELIM = 2'd2
  } inv_state_e;

  function automatic nn_matrix_t identity_matrix();
    nn_matrix_t m;
    m = '0;
    for (int r = 0; r < N; r++) begin
      m[r][r] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/matrix_inverter_pivot_finder.sv
// Combinational pivot search: lowest row index at or below col whose bit in
// the current column is set.
module pivot_finder #(
  parameter int NR = 8,
  parameter int CW = $clog2(NR)
) (
  input  logic [NR-1:0] col_vec,
  input  logic [CW-1:0] col,
  output logic          found,
  output logic [CW-1:0] idx
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int r = NR - 1; r >= 0; r--) begin
      if (col_vec[r] && (CW'(r) >= col)) begin
        found = 1'b1;
        idx   = CW'(r);
      end
    end
  end

endmodule

// File: rtl/matrix_inverter.sv
// Sequential GF(2) Gauss-Jordan inverter: one SWAP and one ELIM cycle per
// column, flags singular matrices, holds the last result.
module matrix_inverter
  import matrix_inverter_pkg::*;
#(
  parameter int d = D,
  localparam int ORD = 8 + d,
  localparam int CW = $clog2(8 + d)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ORD-1:0][ORD-1:0]  matrix,
  output logic                     busy,
  output logic                     done,
  output logic                     singular,
  output logic [ORD-1:0][ORD-1:0]  inverse,
  output inv_state_e               dbg_state
);

  // Handshake: start is a level sampled on a rising edge only while idle;
  // done is a one-cycle pulse and is never high together with busy.

  typedef logic [ORD-1:0][ORD-1:0] mat_t;

  inv_state_e    state_q, state_d;
  mat_t          a_q, a_d;
  mat_t          b_q, b_d;
  logic [CW-1:0] col_q, col_d;
  logic          singular_q, singular_d;
  mat_t          inverse_q, inverse_d;
  logic          done_q, done_d;

  logic [ORD-1:0] col_vec;
  logic [ORD-1:0] elim_hit;
  logic           piv_found;
  logic [CW-1:0]  piv_idx;
  mat_t           ident;
  mat_t           swap_a, swap_b;
  mat_t           elim_a, elim_b;

  pivot_finder #(
    .NR (ORD),
    .CW (CW)
  ) u_pivot (
    .col_vec (col_vec),
    .col     (col_q),
    .found   (piv_found),
    .idx     (piv_idx)
  );

  for (genvar r = 0; r < ORD; r++) begin : g_row
    localparam logic [CW-1:0] RI = CW'(r);

    assign col_vec[r] = a_q[r][col_q];
    assign ident[r]   = ORD'(1) << r;

    // Row exchange of pivot row and row col; degenerates to identity if equal.
    assign swap_a[r] = (RI == col_q)   ? a_q[piv_idx] :
                       (RI == piv_idx) ? a_q[col_q]   : a_q[r];
    assign swap_b[r] = (RI == col_q)   ? b_q[piv_idx] :
                       (RI == piv_idx) ? b_q[col_q]   : b_q[r];

    assign elim_hit[r] = (RI != col_q) && a_q[r][col_q];
    assign elim_a[r]   = elim_hit[r] ? (a_q[r] ^ a_q[col_q]) : a_q[r];
    assign elim_b[r]   = elim_hit[r] ? (b_q[r] ^ b_q[col_q]) : b_q[r];
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    col_d      = col_q;
    singular_d = singular_q;
    inverse_d  = inverse_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = matrix;
          b_d        = ident;
          col_d      = '0;
          singular_d = 1'b0;
          state_d    = SWAP;
        end
      end
      SWAP: begin
        if (piv_found) begin
          a_d     = swap_a;
          b_d     = swap_b;
          state_d = ELIM;
        end else begin
          singular_d = 1'b1;
          inverse_d  = '0;
          done_d     = 1'b1;
          col_d      = '0;
          state_d    = IDLE;
        end
      end
      ELIM: begin
        a_d = elim_a;
        b_d = elim_b;
        if (col_q == CW'(ORD - 1)) begin
          inverse_d = elim_b;
          done_d    = 1'b1;
          col_d     = '0;
          state_d   = IDLE;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = SWAP;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      singular_q <= 1'b0;
      inverse_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      singular_q <= singular_d;
      inverse_q  <= inverse_d;
      done_q     <= done_d;
    end
  end

  // Working matrices carry no meaning outside SWAP/ELIM, so they skip reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign singular  = singular_q;
  assign inverse   = inverse_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_inverter.sv
// Directed and randomised checks of matrix_inverter for d=0 and d=2.
module tb_matrix_inverter;
  import matrix_inverter_pkg::*;

  typedef logic [7:0][7:0] m8_t;
  typedef logic [9:0][9:0] m10_t;

  logic       clk;
  logic       rst_n;
  logic       start0, busy0, done0, sing0;
  m8_t        m0, inv0;
  inv_state_e st0;
  logic       start2, busy2, done2, sing2;
  m10_t       m2, inv2;
  inv_state_e st2;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  matrix_inverter #(.d(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .matrix(m0),
    .busy(busy0), .done(done0), .singular(sing0), .inverse(inv0),
    .dbg_state(st0)
  );

  matrix_inverter #(.d(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .matrix(m2),
    .busy(busy2), .done(done2), .singular(sing2), .inverse(inv2),
    .dbg_state(st2)
  );

  // ---------------- reference helpers ----------------
  function automatic logic [9:0] mat_vec(input m10_t m, input logic [9:0] x, input int n);
    logic [9:0] y;
    y = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        y[r] = y[r] ^ (m[r][c] & x[c]);
    return y;
  endfunction

  function automatic m10_t gf_mul(input m10_t a, input m10_t b, input int n);
    m10_t p;
    p = '0;
    for (int r = 0; r < n; r++)
      for (int k = 0; k < n; k++)
        for (int j = 0; j < n; j++)
          p[r][k] = p[r][k] ^ (a[r][j] & b[j][k]);
    return p;
  endfunction

  // Unit-lower times unit-upper: always invertible.
  function automatic m10_t rand_inv(input int n);
    m10_t l, u;
    l = '0;
    u = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        if (c < r) l[r][c] = 1'($urandom_range(0, 1));
        if (c > r) u[r][c] = 1'($urandom_range(0, 1));
        if (c == r) begin l[r][c] = 1'b1; u[r][c] = 1'b1; end
      end
    return gf_mul(l, u, n);
  endfunction

  function automatic m8_t to8(input m10_t m);
    m8_t o;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        o[r][c] = m[r][c];
    return o;
  endfunction

  function automatic m10_t from8(input m8_t m);
    m10_t o;
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        o[r][c] = m[r][c];
    return o;
  endfunction

  function automatic m8_t rand8();
    m8_t o;
    for (int r = 0; r < 8; r++) o[r] = 8'($urandom);
    return o;
  endfunction

  function automatic m10_t rand10();
    m10_t o;
    for (int r = 0; r < 10; r++) o[r] = 10'($urandom);
    return o;
  endfunction

  function automatic m8_t anti_diag();
    m8_t o;
    o = '0;
    for (int r = 0; r < 8; r++) o[r][7-r] = 1'b1;
    return o;
  endfunction

  function automatic m8_t upper_ones();
    m8_t o;
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = r; c < 8; c++) o[r][c] = 1'b1;
    return o;
  endfunction

  function automatic m8_t bidiag();
    m8_t o;
    o = '0;
    for (int r = 0; r < 8; r++) begin
      o[r][r] = 1'b1;
      if (r < 7) o[r][r+1] = 1'b1;
    end
    return o;
  endfunction

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic start0_pulse(input m8_t m);
    start0 = 1'b1;
    m0     = m;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    m0     = rand8();
  endtask

  // j = number of rising edges after the accepting edge when done is seen.
  task automatic wait_done0(input int repulse_at, output int j, output bit busy_bad);
    j = 0;
    busy_bad = 1'b0;
    @(negedge clk);
    while (!done0 && j < 100) begin
      if (!busy0) busy_bad = 1'b1;
      start0 = (j == repulse_at);
      m0     = rand8();
      @(negedge clk);
      j++;
    end
    start0 = 1'b0;
    if (busy0) busy_bad = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    start0 = 1'b0; m0 = '0;
    start2 = 1'b0; m2 = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy0, done0, sing0} !== 3'b000 || inv0 !== '0 || st0 !== IDLE) begin
      $display("FAIL reset_d0: busy=%b done=%b sing=%b inv=%h state=%0d, want all zero/IDLE",
               busy0, done0, sing0, inv0, st0);
      n_fail++;
    end
    n_tests++;
    if ({busy2, done2, sing2} !== 3'b000 || inv2 !== '0 || st2 !== IDLE) begin
      $display("FAIL reset_d2: busy=%b done=%b sing=%b inv=%h state=%0d, want all zero/IDLE",
               busy2, done2, sing2, inv2, st2);
      n_fail++;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy0, done0);
      n_fail++;
    end
  endtask

  task automatic test_identity();
    int j;
    bit bb;
    start0_pulse(identity_matrix());
    wait_done0(-1, j, bb);
    n_tests++;
    if (j !== 16) begin
      $display("FAIL identity_latency: got %0d want 16", j); n_fail++;
    end
    n_tests++;
    if (bb) begin
      $display("FAIL identity_busy: busy not high before done or high with done"); n_fail++;
    end
    n_tests++;
    if (inv0 !== identity_matrix() || sing0 !== 1'b0) begin
      $display("FAIL identity_result: inv=%h sing=%b want %h 0", inv0, sing0, identity_matrix());
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (done0 !== 1'b0 || inv0 !== identity_matrix()) begin
      $display("FAIL done_pulse: done=%b inv=%h want 0 and held identity", done0, inv0);
      n_fail++;
    end
  endtask

  task automatic test_anti_diag();
    int j;
    bit bb;
    start0_pulse(anti_diag());
    wait_done0(-1, j, bb);
    n_tests++;
    if (j !== 16 || inv0 !== anti_diag() || sing0 !== 1'b0) begin
      $display("FAIL anti_diag: lat=%0d inv=%h sing=%b want 16 %h 0", j, inv0, sing0, anti_diag());
      n_fail++;
    end
  endtask

  task automatic test_upper();
    int j;
    bit bb;
    start0_pulse(upper_ones());
    wait_done0(-1, j, bb);
    n_tests++;
    if (j !== 16 || inv0 !== bidiag() || sing0 !== 1'b0) begin
      $display("FAIL upper_tri: lat=%0d inv=%h sing=%b want 16 %h 0", j, inv0, sing0, bidiag());
      n_fail++;
    end
  endtask

  task automatic test_singular();
    int j;
    bit bb;
    m8_t m;
    m = identity_matrix();
    m[3] = '0;
    start0_pulse(m);
    wait_done0(-1, j, bb);
    n_tests++;
    if (j !== 7 || sing0 !== 1'b1 || inv0 !== '0) begin
      $display("FAIL singular_row3: lat=%0d sing=%b inv=%h want 7 1 0", j, sing0, inv0);
      n_fail++;
    end
    start0_pulse(identity_matrix());
    wait_done0(-1, j, bb);
    n_tests++;
    if (j !== 16 || sing0 !== 1'b0 || inv0 !== identity_matrix()) begin
      $display("FAIL singular_recover: lat=%0d sing=%b inv=%h want 16 0 identity", j, sing0, inv0);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int j;
    bit bb;
    start0_pulse(upper_ones());
    wait_done0(-1, j, bb);
    n_tests++;
    if (inv0 !== bidiag()) begin
      $display("FAIL b2b_first: inv=%h want %h", inv0, bidiag()); n_fail++;
    end
    // New start during the done cycle.
    start0_pulse(anti_diag());
    wait_done0(-1, j, bb);
    n_tests++;
    if (j !== 16 || inv0 !== anti_diag() || bb) begin
      $display("FAIL b2b_second: lat=%0d inv=%h busy_bad=%b want 16 %h 0", j, inv0, bb, anti_diag());
      n_fail++;
    end
  endtask

  task automatic test_random_d0();
    int j;
    bit bb;
    m10_t m;
    logic [9:0] x, y, xr;
    for (int t = 0; t < 200; t++) begin
      m = rand_inv(8);
      start0_pulse(to8(m));
      wait_done0(3, j, bb);
      n_tests++;
      if (j !== 16 || sing0 !== 1'b0) begin
        $display("FAIL rand_d0_lat: mat %0d lat=%0d sing=%b want 16 0", t, j, sing0);
        n_fail++;
      end
      n_tests++;
      begin
        bit bad;
        bad = 1'b0;
        for (int v = 0; v < 16 && !bad; v++) begin
          x  = {2'b00, 8'($urandom)};
          y  = mat_vec(m, x, 8);
          xr = mat_vec(from8(inv0), y, 8);
          if (xr !== x) begin
            $display("FAIL rand_d0_decode: mat %0d x=%h got %h want %h", t, x, xr, x);
            bad = 1'b1;
          end
        end
        if (bad) n_fail++;
      end
    end
  endtask

  task automatic test_random_d2();
    int j;
    m10_t m;
    logic [9:0] x, y, xr;
    for (int t = 0; t < 200; t++) begin
      m = rand_inv(10);
      start2 = 1'b1;
      m2     = m;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      m2     = rand10();
      j = 0;
      @(negedge clk);
      while (!done2 && j < 100) begin
        start2 = (j == 5);
        m2     = rand10();
        @(negedge clk);
        j++;
      end
      start2 = 1'b0;
      n_tests++;
      if (j !== 20 || sing2 !== 1'b0) begin
        $display("FAIL rand_d2_lat: mat %0d lat=%0d sing=%b want 20 0", t, j, sing2);
        n_fail++;
      end
      n_tests++;
      begin
        bit bad;
        bad = 1'b0;
        for (int v = 0; v < 16 && !bad; v++) begin
          x  = 10'($urandom);
          y  = mat_vec(m, x, 10);
          xr = mat_vec(inv2, y, 10);
          if (xr !== x) begin
            $display("FAIL rand_d2_decode: mat %0d x=%h got %h want %h", t, x, xr, x);
            bad = 1'b1;
          end
        end
        if (bad) n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int j;
    bit bb;
    start0_pulse(upper_ones());
    wait_done0(-1, j, bb);
    start0_pulse(anti_diag());
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy0, done0, sing0} !== 3'b000 || inv0 !== '0 || st0 !== IDLE) begin
      $display("FAIL reset_mid: busy=%b done=%b sing=%b inv=%h state=%0d want all zero/IDLE",
               busy0, done0, sing0, inv0, st0);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start0_pulse(upper_ones());
    wait_done0(-1, j, bb);
    n_tests++;
    if (j !== 16 || inv0 !== bidiag() || sing0 !== 1'b0) begin
      $display("FAIL reset_mid_restart: lat=%0d inv=%h sing=%b want 16 %h 0", j, inv0, sing0, bidiag());
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_anti_diag();
    test_upper();
    test_singular();
    test_back_to_back();
    test_random_d0();
    test_random_d2();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
